// File: rtl/os_tx_scheduler.sv
// os_tx_scheduler: per-lane TX symbol arbiter between link data and
// LTSSM ordered sets (TS1/TS2/FTS/SKP/EIOS) with periodic SKP insertion.
module os_tx_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned TS_LEN       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ts1_req,
  input  logic       ts2_req,
  input  logic       fts_req,
  input  logic [7:0] n_fts,
  input  logic       eios_req,
  input  logic       data_valid,
  input  logic [7:0] data_sym,
  input  logic       data_k,
  input  logic       data_last,
  output logic       data_ready,
  output logic [7:0] tx_sym,
  output logic       tx_k,
  output logic       tx_valid,
  output logic       tx_elec_idle,
  output logic       fts_sent,
  output logic       skp_pending
);
  localparam int unsigned CW = $clog2(SKP_INTERVAL + 1);
  localparam int unsigned SW = $clog2(TS_LEN + 1);
  localparam logic [CW-1:0] SKP_MAX = CW'(SKP_INTERVAL - 1);
  localparam logic [SW-1:0] TS_LAST = SW'(TS_LEN - 1);
  localparam logic [SW-1:0] OS4_LAST = SW'(3);
  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    ST_EIDLE, ST_LIDLE, ST_DATA, ST_OS
  } state_e;

  typedef enum logic [2:0] {
    OS_TS1, OS_TS2, OS_FTS, OS_SKP, OS_EIOS
  } os_e;

  typedef enum logic [2:0] {
    SEL_EIOS, SEL_SKP, SEL_FTS, SEL_TS2,
    SEL_TS1, SEL_DATA, SEL_IDLE, SEL_NONE
  } sel_e;

  state_e        state_q, state_d;
  os_e           os_q, os_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [7:0]    nfts_q, nfts_d;
  logic [7:0]    fts_left_q, fts_left_d;
  logic          burst_q, burst_d;
  logic          trailer_q, trailer_d;
  logic          fts_pend_q, fts_pend_d;
  logic          eios_pend_q, eios_pend_d;
  logic [CW-1:0] skp_cnt_q, skp_cnt_d;
  logic          skp_pend_q, skp_pend_d;
  logic [7:0]    tx_sym_q, tx_sym_d;
  logic          tx_k_q, tx_k_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_eidle_q, tx_eidle_d;
  logic          fts_sent_q, fts_sent_d;

  sel_e          sel;
  logic          fts_any, eios_any;
  logic          start;
  os_e           start_type;
  logic [SW-1:0] os_last;
  logic [8:0]    os_out;

  function automatic logic [8:0] os_sym(
    input os_e           t,
    input logic [SW-1:0] i,
    input logic [7:0]    nf
  );
    logic [8:0] r;
    r = {1'b1, COM};
    if (i != '0) begin
      unique case (t)
        OS_FTS:  r = {1'b1, 8'h3C};
        OS_SKP:  r = {1'b1, 8'h1C};
        OS_EIOS: r = {1'b1, 8'h7C};
        default: begin
          if (i < SW'(3))       r = {1'b1, 8'hF7};
          else if (i == SW'(3)) r = {1'b0, nf};
          else if (i == SW'(4)) r = {1'b0, 8'h02};
          else if (i == SW'(5)) r = {1'b0, 8'h00};
          else r = {1'b0, (t == OS_TS2) ? 8'h45 : 8'h4A};
        end
      endcase
    end
    return r;
  endfunction

  assign fts_any  = fts_pend_q | fts_req;
  assign eios_any = eios_pend_q | eios_req;
  assign os_last  = (os_q == OS_TS1 || os_q == OS_TS2)
                  ? TS_LAST : OS4_LAST;
  assign os_out   = os_sym(os_q, sym_cnt_q, nfts_q);

  // Boundary arbitration; ELEC_IDLE only wakes for TS or FTS.
  always_comb begin
    sel = SEL_NONE;
    if (state_q == ST_LIDLE) begin
      if (eios_any)                 sel = SEL_EIOS;
      else if (skp_pend_q)          sel = SEL_SKP;
      else if (burst_q || fts_any)  sel = SEL_FTS;
      else if (ts2_req)             sel = SEL_TS2;
      else if (ts1_req)             sel = SEL_TS1;
      else if (data_valid)          sel = SEL_DATA;
      else                          sel = SEL_IDLE;
    end else if (state_q == ST_EIDLE) begin
      if (burst_q || fts_any)       sel = SEL_FTS;
      else if (ts2_req)             sel = SEL_TS2;
      else if (ts1_req)             sel = SEL_TS1;
    end
  end

  assign data_ready = (state_q == ST_DATA) ||
                      (sel == SEL_DATA) || (sel == SEL_IDLE);

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    sym_cnt_d   = sym_cnt_q;
    nfts_d      = nfts_q;
    fts_left_d  = fts_left_q;
    burst_d     = burst_q;
    trailer_d   = trailer_q;
    fts_pend_d  = fts_pend_q | (fts_req & ~burst_q);
    eios_pend_d = eios_pend_q |
                  (eios_req & (state_q != ST_EIDLE));
    skp_cnt_d   = skp_cnt_q;
    skp_pend_d  = skp_pend_q;
    tx_sym_d    = 8'h00;
    tx_k_d      = 1'b0;
    tx_valid_d  = 1'b0;
    tx_eidle_d  = 1'b0;
    fts_sent_d  = 1'b0;
    start       = 1'b0;
    start_type  = OS_TS1;

    unique case (state_q)
      ST_EIDLE: tx_eidle_d = 1'b1;
      ST_DATA: begin
        if (data_valid) begin
          tx_sym_d   = data_sym;
          tx_k_d     = data_k;
          tx_valid_d = 1'b1;
          if (data_last) state_d = ST_LIDLE;
        end
      end
      ST_OS: begin
        {tx_k_d, tx_sym_d} = os_out;
        tx_valid_d = 1'b1;
        sym_cnt_d  = sym_cnt_q + SW'(1);
        if (sym_cnt_q == os_last) begin
          sym_cnt_d = '0;
          state_d   = (os_q == OS_EIOS) ? ST_EIDLE : ST_LIDLE;
          if (os_q == OS_SKP && trailer_q) begin
            fts_sent_d = 1'b1;
            burst_d    = 1'b0;
            trailer_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase

    unique case (sel)
      SEL_EIOS: begin
        start       = 1'b1;
        start_type  = OS_EIOS;
        eios_pend_d = 1'b0;
      end
      SEL_SKP: begin
        start      = 1'b1;
        start_type = OS_SKP;
      end
      SEL_FTS: begin
        start      = 1'b1;
        fts_pend_d = 1'b0;
        burst_d    = 1'b1;
        if (!burst_q) begin
          if (n_fts == 8'd0) begin
            start_type = OS_SKP;
            trailer_d  = 1'b1;
          end else begin
            start_type = OS_FTS;
            fts_left_d = n_fts - 8'd1;
          end
        end else if (fts_left_q == 8'd0) begin
          start_type = OS_SKP;
          trailer_d  = 1'b1;
        end else begin
          start_type = OS_FTS;
          fts_left_d = fts_left_q - 8'd1;
        end
      end
      SEL_TS2: begin
        start      = 1'b1;
        start_type = OS_TS2;
        nfts_d     = n_fts;
      end
      SEL_TS1: begin
        start      = 1'b1;
        start_type = OS_TS1;
        nfts_d     = n_fts;
      end
      SEL_DATA: begin
        tx_sym_d   = data_sym;
        tx_k_d     = data_k;
        tx_valid_d = 1'b1;
        if (!data_last) state_d = ST_DATA;
      end
      SEL_IDLE: tx_valid_d = 1'b1;
      default: ;
    endcase

    if (start) begin
      state_d    = ST_OS;
      os_d       = start_type;
      sym_cnt_d  = SW'(1);
      tx_sym_d   = COM;
      tx_k_d     = 1'b1;
      tx_valid_d = 1'b1;
      tx_eidle_d = 1'b0;
    end

    // One owed SKP at most: the counter saturates until a SKP starts.
    if ((start && start_type == OS_SKP) || tx_eidle_d) begin
      skp_cnt_d  = '0;
      skp_pend_d = 1'b0;
    end else if (tx_valid_d) begin
      if (skp_cnt_q != SKP_MAX) skp_cnt_d = skp_cnt_q + CW'(1);
      if (skp_cnt_q == SKP_MAX - CW'(1)) skp_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EIDLE;
      os_q        <= OS_TS1;
      sym_cnt_q   <= '0;
      nfts_q      <= 8'h00;
      fts_left_q  <= 8'h00;
      burst_q     <= 1'b0;
      trailer_q   <= 1'b0;
      fts_pend_q  <= 1'b0;
      eios_pend_q <= 1'b0;
      skp_cnt_q   <= '0;
      skp_pend_q  <= 1'b0;
      tx_sym_q    <= 8'h00;
      tx_k_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_eidle_q  <= 1'b1;
      fts_sent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_q        <= os_d;
      sym_cnt_q   <= sym_cnt_d;
      nfts_q      <= nfts_d;
      fts_left_q  <= fts_left_d;
      burst_q     <= burst_d;
      trailer_q   <= trailer_d;
      fts_pend_q  <= fts_pend_d;
      eios_pend_q <= eios_pend_d;
      skp_cnt_q   <= skp_cnt_d;
      skp_pend_q  <= skp_pend_d;
      tx_sym_q    <= tx_sym_d;
      tx_k_q      <= tx_k_d;
      tx_valid_q  <= tx_valid_d;
      tx_eidle_q  <= tx_eidle_d;
      fts_sent_q  <= fts_sent_d;
    end
  end

  assign tx_sym       = tx_sym_q;
  assign tx_k         = tx_k_q;
  assign tx_valid     = tx_valid_q;
  assign tx_elec_idle = tx_eidle_q;
  assign fts_sent     = fts_sent_q;
  assign skp_pending  = skp_pend_q;

endmodule

// File: doc/os_tx_scheduler.md
# os_tx_scheduler

Transmit-side ordered-set scheduler between the LTSSM and the lane serializer. It owns the single per-lane symbol stream and arbitrates it between link-layer data and the ordered sets the LTSSM needs: TS1, TS2, FTS, SKP and EIOS. SKP sets are inserted periodically, FTS bursts are sequenced on request, and `fts_sent` is returned to the LTSSM. One symbol (8b + K flag) is emitted per clock.

## Interface
- `SKP_INTERVAL`, default 1180: count of emitted symbols between SKP insertions.
- `TS_LEN`, default 16: TS1/TS2 length in symbols.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ts1_req` in 1: level; the LTSSM wants TS1 sent continuously.
- `ts2_req` in 1: level; TS2 continuously (wins over `ts1_req`).
- `fts_req` in 1: pulse; send an FTS burst.
- `n_fts` in 8: number of FTS sets per burst, sampled when the burst starts.
- `eios_req` in 1: pulse; send one EIOS, then enter electrical idle.
- `data_valid` in 1: data symbol valid.
- `data_sym` in 8: data symbol.
- `data_k` in 1: data K flag.
- `data_last` in 1: last symbol of the packet.
- `data_ready` out 1: data symbol accepted this cycle (combinational).
- `tx_sym` out 8: registered output symbol.
- `tx_k` out 1: registered output K flag.
- `tx_valid` out 1: `tx_sym` is meaningful.
- `tx_elec_idle` out 1: transmitter is in electrical idle.
- `fts_sent` out 1: one-cycle pulse, to the LTSSM.
- `skp_pending` out 1: a SKP set is owed.

## Operation
- **States:**
  - ELEC_IDLE (reset state).
  - LOGIC_IDLE.
  - DATA.
  - SEND_OS, with registers `os_type` ∈ {TS1, TS2, FTS, SKP, EIOS} and `sym_cnt`.
- **Ordered-set encoding** (symbol 0 is always COM = 0xBC, k=1):
  - TS1/TS2:
    - Symbols 1–2: PAD 0xF7 (k=1).
    - Symbol 3: latched `n_fts`.
    - Symbol 4: 0x02.
    - Symbol 5: 0x00.
    - Symbols 6..`TS_LEN`-1: 0x4A (TS1) or 0x45 (TS2).
  - FTS: COM + 3× 0x3C (k=1).
  - SKP: COM + 3× 0x1C (k=1).
  - EIOS: COM + 3× 0x7C (k=1).
- **Logical idle:** 0x00, k=0, `tx_valid`=1.
- **Decision point (boundary):** any cycle in LOGIC_IDLE; the last symbol of an ordered set; or a data beat accepted with `data_last`=1.
  - Priority at a boundary: EIOS pending > SKP pending > FTS burst > TS2 > TS1 > data > logical idle.
  - An ordered set is never interrupted.
  - A packet is never interrupted once its first symbol is accepted.
- **DATA state:**
  - `data_ready` = 1 while in DATA, and in LOGIC_IDLE when data wins arbitration.
  - A mid-packet `data_valid`=0 produces a bubble: `tx_valid`=0.
- **FTS burst:**
  - `fts_req` is latched.
  - The burst is `n_fts` FTS sets followed by exactly one SKP.
  - `fts_sent` pulses with the final SKP symbol.
  - The trailing SKP also clears `skp_pending` and the SKP counter.
  - `n_fts`=0 sends the SKP only.
- **EIOS:**
  - `eios_req` is latched; the EIOS is sent at the next boundary.
  - After the EIOS, the state goes to ELEC_IDLE.
  - ELEC_IDLE outputs: `tx_valid`=0, `tx_elec_idle`=1, `data_ready`=0.
  - ELEC_IDLE is left only on `ts1_req`, `ts2_req` or pending FTS. The first COM follows on the next cycle, with `tx_elec_idle` deasserted on that same cycle.
- **SKP counter:**
  - Increments on every cycle with `tx_valid`=1.
  - At `SKP_INTERVAL`-1 it sets `skp_pending` and saturates; owed SKPs never accumulate beyond one.
  - It is cleared when a SKP set starts.
  - It is held at 0 in ELEC_IDLE.
- **Simultaneous events:**
  - `eios_req` together with an FTS pending: EIOS is sent first. The FTS stays latched and wakes the link from ELEC_IDLE.
  - A repeat `fts_req` during a burst is ignored.

## Timing
- Reset values:
  - `tx_sym`=0x00, `tx_k`=0, `tx_valid`=0.
  - `tx_elec_idle`=1.
  - `fts_sent`=0, `skp_pending`=0.
  - State ELEC_IDLE, all latches clear.
- Latency is one cycle:
  - A data symbol accepted in cycle N appears on `tx_sym` in cycle N+1.
  - A request seen at a boundary in cycle N puts COM on `tx_sym` in cycle N+1.
- An ordered set occupies consecutive cycles with no gaps.
- `fts_sent` is a registered pulse coincident with the last symbol of the trailing SKP.
- Asserting `reset_n` low mid-set aborts the set immediately and forces the reset values.

## Test plan
- **Reset to TS1:** reset, then `ts1_req`=1 → first COM one cycle after `ts1_req` is seen; back-to-back 16-symbol TS1 with symbols 6–15 = 0x4A; `tx_elec_idle`=0 from the first COM.
- **TS2 over TS1:** assert `ts2_req` mid-TS1 → current TS1 completes, then TS2 starts (symbol 6 = 0x45).
- **FTS burst:** `n_fts`=3, pulse `fts_req` from ELEC_IDLE → 3×FTS + 1×SKP (16 symbols), `fts_sent` high on symbol 16 only.
- **SKP insertion:** `SKP_INTERVAL`=20, continuous 30-symbol packet → SKP deferred until after `data_last`, appears next cycle; `skp_pending` high from symbol 19 until the SKP COM.
- **EIOS:** `eios_req` during a packet → packet completes, EIOS (BC,7C,7C,7C), then `tx_valid`=0, `tx_elec_idle`=1, `data_ready`=0.
- **Reset mid-TS1:** pull `reset_n` low at symbol 7 of a TS1 → outputs reach reset values immediately.
